// File: rtl/song_sequencer.sv
// Two-hand melody player: walks a small writable song memory and drives the
// note-to-divider inputs, with optional articulation gaps, looping and abort.
module song_sequencer #(
   parameter int BEAT_CYCLES = 25000000,
   parameter int GAP_CYCLES  = 1000000,
   parameter int SONG_LEN    = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       loop,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [9:0] wr_data,
   output logic [3:0] left_note,
   output logic [3:0] right_note,
   output logic       stop,
   output logic [4:0] pos,
   output logic       busy,
   output logic       done
);

   localparam int CNT_MAX = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int AW      = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
   localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [5:0]    LEN6      = 6'(SONG_LEN);

   typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

   state_t        state_q, state_d;
   logic [4:0]    pos_q, pos_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [1:0]    beat_q, beat_d;
   logic [1:0]    len_q, len_d;
   logic [3:0]    left_q, left_d;
   logic [3:0]    right_q, right_d;
   logic          stop_q, stop_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [9:0]    mem_q [SONG_LEN];
   logic [9:0]    mem_d [SONG_LEN];

   logic [4:0]    pos_inc;
   logic [9:0]    next_entry;
   logic          has_next;
   logic          adv, load, finish;
   logic [4:0]    load_pos;
   logic [9:0]    load_entry;

   function automatic logic is_end(input logic [9:0] e);
      return e[9:2] == 8'hFF;
   endfunction

   assign pos_inc    = pos_q + 5'd1;
   assign next_entry = mem_q[pos_inc[AW-1:0]];
   assign has_next   = (({1'b0, pos_q} + 6'd1) < LEN6) && !is_end(next_entry);

   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      cyc_d      = cyc_q + 1'b1;
      beat_d     = beat_q;
      len_d      = len_q;
      left_d     = left_q;
      right_d    = right_q;
      stop_d     = stop_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      mem_d      = mem_q;
      adv        = 1'b0;
      load       = 1'b0;
      finish     = 1'b0;
      load_pos   = '0;
      load_entry = '0;

      case (state_q)
         IDLE: begin
            cyc_d = '0;
            if (start) begin
               if (is_end(mem_q[0])) finish = 1'b1;
               else                  load   = 1'b1;
            end
         end
         NOTE: begin
            if (cyc_q == BEAT_LAST) begin
               cyc_d = '0;
               if (beat_q == len_q) begin
                  if (GAP_CYCLES > 0) begin
                     state_d = GAP;
                     stop_d  = 1'b1;
                     beat_d  = '0;
                  end else begin
                     adv = 1'b1;
                  end
               end else begin
                  beat_d = beat_q + 2'd1;
               end
            end
         end
         GAP: begin
            if (cyc_q == GAP_LAST) adv = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // End of an entry: step forward, wrap on loop, or finish the song.
      if (adv) begin
         if (has_next) begin
            load     = 1'b1;
            load_pos = pos_inc;
         end else if (loop && !is_end(mem_q[0])) begin
            load = 1'b1;
         end else begin
            finish = 1'b1;
         end
      end

      if (load) begin
         load_entry = mem_q[load_pos[AW-1:0]];
         state_d    = NOTE;
         pos_d      = load_pos;
         left_d     = load_entry[9:6];
         right_d    = load_entry[5:2];
         len_d      = load_entry[1:0];
         stop_d     = 1'b0;
         busy_d     = 1'b1;
         cyc_d      = '0;
         beat_d     = '0;
      end

      if (finish || abort) begin
         state_d = IDLE;
         pos_d   = '0;
         left_d  = '0;
         right_d = '0;
         stop_d  = 1'b1;
         busy_d  = 1'b0;
         cyc_d   = '0;
         beat_d  = '0;
         done_d  = finish && !abort;
      end

      if (wr_en && ({1'b0, wr_addr} < LEN6)) mem_d[wr_addr[AW-1:0]] = wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pos_q   <= '0;
         cyc_q   <= '0;
         beat_q  <= '0;
         len_q   <= '0;
         left_q  <= '0;
         right_q <= '0;
         stop_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mem_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         cyc_q   <= cyc_d;
         beat_q  <= beat_d;
         len_q   <= len_d;
         left_q  <= left_d;
         right_q <= right_d;
         stop_q  <= stop_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mem_q   <= mem_d;
      end
   end

   assign left_note  = left_q;
   assign right_note = right_q;
   assign stop       = stop_q;
   assign pos        = pos_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: two instances (with and without the
// articulation gap) checked cycle by cycle against an entry-timeline model.
module tb_song_sequencer;

   localparam int BEAT = 4;
   localparam int GAP  = 2;
   localparam int SLEN = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, abort = 1'b0, loop = 1'b0, wr_en = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [9:0] wr_data = '0;

   logic [3:0] ln_g, rn_g, ln_n, rn_n;
   logic       stop_g, busy_g, done_g, stop_n, busy_n, done_n;
   logic [4:0] pos_g, pos_n;

   typedef struct packed {
      logic [3:0] l;
      logic [3:0] r;
      logic       stop;
      logic [4:0] pos;
      logic       busy;
      logic       done;
   } out_t;

   typedef struct {
      int   tag;
      out_t o;
   } exp_t;

   out_t       act [2];
   out_t       tl [2][$];
   exp_t       exp_q [2][$];
   logic [9:0] mmem [SLEN];
   bit         playing [2];
   int         mpos [2];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic       lp_lvl = 1'b0;

   song_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .SONG_LEN(SLEN)) dut_g (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop(loop),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .left_note(ln_g), .right_note(rn_g), .stop(stop_g), .pos(pos_g),
      .busy(busy_g), .done(done_g)
   );

   song_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(0), .SONG_LEN(SLEN)) dut_n (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop(loop),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .left_note(ln_n), .right_note(rn_n), .stop(stop_n), .pos(pos_n),
      .busy(busy_n), .done(done_n)
   );

   assign act[0] = {ln_g, rn_g, stop_g, pos_g, busy_g, done_g};
   assign act[1] = {ln_n, rn_n, stop_n, pos_n, busy_n, done_n};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input out_t a, input out_t e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s cyc=%0d got l=%0d r=%0d stop=%0b pos=%0d busy=%0b done=%0b want l=%0d r=%0d stop=%0b pos=%0d busy=%0b done=%0b",
                  nm, cyc, a.l, a.r, a.stop, a.pos, a.busy, a.done,
                  e.l, e.r, e.stop, e.pos, e.busy, e.done);
      end
   endtask

   // Monitor: compares each instance against whatever the scoreboard holds for this cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            if (exp_q[d].size() > 0 && exp_q[d][0].tag == cyc) begin
               e = exp_q[d].pop_front();
               cmp((d == 0) ? "out_gap" : "out_nogap", act[d], e.o);
            end
         end
      end
   end

   function automatic out_t mk(input int l, input int r, input bit s, input int p,
                               input bit b, input bit dn);
      out_t o;
      o.l = 4'(l); o.r = 4'(r); o.stop = s; o.pos = 5'(p); o.busy = b; o.done = dn;
      return o;
   endfunction

   function automatic bit is_end(input logic [9:0] e);
      return e[9:2] == 8'hFF;
   endfunction

   // One entry expands into its sounding cycles followed by its silent gap cycles.
   function automatic void expand(input int d, input int p);
      logic [9:0] e = mmem[p];
      int n = (int'(e[1:0]) + 1) * BEAT;
      int g = (d == 0) ? GAP : 0;
      for (int i = 0; i < n; i++) tl[d].push_back(mk(int'(e[9:6]), int'(e[5:2]), 1'b0, p, 1'b1, 1'b0));
      for (int i = 0; i < g; i++) tl[d].push_back(mk(int'(e[9:6]), int'(e[5:2]), 1'b1, p, 1'b1, 1'b0));
   endfunction

   function automatic out_t model_step(input int d, input bit s, input bit a, input bit lp);
      if (a) begin
         tl[d].delete();
         playing[d] = 1'b0;
         return mk(0, 0, 1'b1, 0, 1'b0, 1'b0);
      end
      if (playing[d]) begin
         if (tl[d].size() == 0) begin
            if (mpos[d] + 1 < SLEN && !is_end(mmem[mpos[d] + 1])) begin
               mpos[d]++;
               expand(d, mpos[d]);
            end else if (lp && !is_end(mmem[0])) begin
               mpos[d] = 0;
               expand(d, 0);
            end else begin
               playing[d] = 1'b0;
               return mk(0, 0, 1'b1, 0, 1'b0, 1'b1);
            end
         end
         return tl[d].pop_front();
      end
      if (s) begin
         if (is_end(mmem[0])) return mk(0, 0, 1'b1, 0, 1'b0, 1'b1);
         playing[d] = 1'b1;
         mpos[d] = 0;
         expand(d, 0);
         return tl[d].pop_front();
      end
      return mk(0, 0, 1'b1, 0, 1'b0, 1'b0);
   endfunction

   task automatic step(input bit s, input bit a, input bit we,
                       input logic [4:0] wa, input logic [9:0] wd);
      exp_t e;
      start = s; abort = a; loop = lp_lvl; wr_en = we; wr_addr = wa; wr_data = wd;
      for (int d = 0; d < 2; d++) begin
         e.tag = cyc + 1;
         e.o   = model_step(d, s, a, lp_lvl);
         exp_q[d].push_back(e);
      end
      if (we && wa < 5'(SLEN)) mmem[wa[2:0]] = wd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 10'd0);
   endtask

   task automatic write(input int a, input logic [9:0] d);
      step(1'b0, 1'b0, 1'b1, 5'(a), d);
   endtask

   task automatic basic_song();
      write(0, {4'd1, 4'd5, 2'd1});
      write(1, {4'd8, 4'd3, 2'd0});
      write(2, 10'h3FC);
   endtask

   task automatic check_reset(input string nm);
      cmp({nm, "_gap"},   act[0], mk(0, 0, 1'b1, 0, 1'b0, 1'b0));
      cmp({nm, "_nogap"}, act[1], mk(0, 0, 1'b1, 0, 1'b0, 1'b0));
   endtask

   initial begin
      for (int i = 0; i < SLEN; i++) mmem[i] = '0;
      for (int d = 0; d < 2; d++) begin playing[d] = 1'b0; mpos[d] = 0; end
      #12;
      check_reset("reset_state");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      basic_song();
      step(1'b1, 1'b0, 1'b0, 5'd0, 10'd0);
      idle(25);

      // Abort together with start on the third sounding cycle of entry 1, then replay.
      step(1'b1, 1'b0, 1'b0, 5'd0, 10'd0);
      idle(12);
      step(1'b1, 1'b1, 1'b0, 5'd0, 10'd0);
      idle(3);
      step(1'b1, 1'b0, 1'b0, 5'd0, 10'd0);
      idle(25);

      // End marker at entry 0, then a same-cycle write must not affect the start decision.
      write(0, 10'h3FC);
      step(1'b1, 1'b0, 1'b0, 5'd0, 10'd0);
      idle(3);
      step(1'b1, 1'b0, 1'b1, 5'd0, {4'd2, 4'd7, 2'd0});
      idle(2);
      step(1'b1, 1'b0, 1'b0, 5'd0, 10'd0);
      idle(20);

      // Full memory, looping for two passes, then loop released to end the song.
      for (int i = 0; i < SLEN; i++)
         write(i, {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))});
      lp_lvl = 1'b1;
      step(1'b1, 1'b0, 1'b0, 5'd0, 10'd0);
      idle(300);
      lp_lvl = 1'b0;
      idle(160);
      step(1'b1, 1'b0, 1'b0, 5'd0, 10'd0);
      idle(160);

      for (int i = 0; i < 600; i++) begin
         bit s, a, we;
         logic [9:0] wd;
         s  = ($urandom_range(0, 19) == 0);
         a  = ($urandom_range(0, 59) == 0);
         we = ($urandom_range(0, 7) == 0);
         wd = ($urandom_range(0, 5) == 0) ? {8'hFF, 2'($urandom_range(0, 3))} : 10'($urandom);
         if ($urandom_range(0, 49) == 0) lp_lvl = ~lp_lvl;
         step(s, a, we, 5'($urandom_range(0, 11)), wd);
      end
      lp_lvl = 1'b0;
      step(1'b0, 1'b1, 1'b0, 5'd0, 10'd0);
      idle(2);

      // Asynchronous reset in the middle of a song clears outputs and memory.
      basic_song();
      step(1'b1, 1'b0, 1'b0, 5'd0, 10'd0);
      idle(5);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("async_reset");
      for (int d = 0; d < 2; d++) begin
         tl[d].delete();
         exp_q[d].delete();
         playing[d] = 1'b0;
         mpos[d] = 0;
      end
      for (int i = 0; i < SLEN; i++) mmem[i] = '0;
      start = 1'b0; abort = 1'b0; wr_en = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);
      step(1'b1, 1'b0, 1'b0, 5'd0, 10'd0);
      idle(70);

      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (exp_q[d].size() != 0) begin
            failures++;
            $display("FAIL drain dut=%0d pending=%0d want 0", d, exp_q[d].size());
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
